// File: rtl/muxcont_rr_credit_pkg.sv
// Shared definitions for the output-port contention controller family:
// multicast/absorb status encodings, default field widths, the asserted
// level of active-low controls and the packet-lock state encoding.
package muxcont_rr_credit_pkg;

  // Default widths of the routed-port and status fields carried per input.
  localparam int MC_PORTW = 3;
  localparam int MC_DSTW  = 2;

  // Per-input status field encodings.
  localparam logic [MC_DSTW-1:0] UNICAST = 2'b01;
  localparam logic [MC_DSTW-1:0] MULTABS = 2'b10;

  // Active-low controls (such as rst_) are asserted at this level.
  localparam logic ENABLE_ = 1'b0;

  // Packet-lock state: IDLE arbitrates every cycle, LOCKED serves one owner.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/muxcont_rr_credit_rr_arbiter.sv
// Purely combinational rotating-priority arbiter. Scans the request vector
// starting at ptr and wrapping, and returns the first requester as a one-hot
// grant plus its index. Shared by all output-port controllers.
module muxcont_rr_credit_rr_arbiter #(
  parameter int NPORT = 5,
  parameter int PTRW  = 3
) (
  input  logic [NPORT-1:0] req,
  input  logic [PTRW-1:0]  ptr,
  output logic [NPORT-1:0] gnt,
  output logic [PTRW-1:0]  winner,
  output logic             found
);

  // First requester at or above ptr (with wrap) wins; at most one bit set.
  always_comb begin
    int idx;
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NPORT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NPORT) begin
        idx = idx - NPORT;
      end
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = PTRW'(idx);
      end
    end
  end

endmodule

// File: rtl/muxcont_rr_credit.sv
// Output-port contention controller: one instance per router output.
// Qualifies unicast/multicast requests, arbitrates with a rotating pointer,
// locks the output to one input until its tail flit, registers the crossbar
// select and tracks downstream credits.
// Optional lock-idle timeout: define MUXCONT_LOCK_TIMEOUT_EN.
module muxcont_rr_credit
  import muxcont_rr_credit_pkg::*;
#(
  parameter int NPORT   = 5,
  parameter int PORTID  = 4,
  parameter int PORTW   = MC_PORTW,
  parameter int DSTW    = MC_DSTW,
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [NPORT-1:0]           req,
  input  logic [NPORT*PORTW-1:0]     port,
  input  logic [NPORT*DSTW-1:0]      multab,
  input  logic [NPORT-1:0]           tail,
  input  logic                       credit_in,
  output logic [NPORT-1:0]           grt,
  output logic [NPORT-1:0]           sel,
  output logic [NPORT-1:0]           multab_ct,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic                       credit_ovf,
  output logic                       lock_timeout
);

  localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CNTW = $clog2(CREDITS + 1);

  logic [NPORT-1:0] u_req;
  logic [NPORT-1:0] m_req;
  logic [NPORT-1:0] any_req;

  lock_state_e      state_reg, state_next;
  logic [PTRW-1:0]  ptr_reg, ptr_next;
  logic [PTRW-1:0]  owner_reg, owner_next;
  logic [NPORT-1:0] sel_reg;
  logic [CNTW-1:0]  credit_cnt_reg;
  logic             credit_ovf_reg;

  logic [NPORT-1:0] grt_raw;
  logic [NPORT-1:0] arb_gnt;
  logic [PTRW-1:0]  arb_winner;
  logic             arb_found;
  logic             credit_ok;
  logic             credit_full;
  logic             granted;
  logic             owner_req;
  logic             owner_tail;
  logic             lock_expire;
  logic             out_en;

  // Per-input qualification: unicast flits must target this port, multicast
  // flits contend for every output regardless of their port field.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_qual
    assign u_req[gi] = req[gi]
                     & (multab[gi*DSTW +: DSTW] == DSTW'(UNICAST))
                     & (port[gi*PORTW +: PORTW] == PORTW'(PORTID));
    assign m_req[gi] = req[gi] & (multab[gi*DSTW +: DSTW] == DSTW'(MULTABS));
  end

  assign any_req = u_req | m_req;

  muxcont_rr_credit_rr_arbiter #(
    .NPORT (NPORT),
    .PTRW  (PTRW)
  ) u_arb (
    .req    (any_req),
    .ptr    (ptr_reg),
    .gnt    (arb_gnt),
    .winner (arb_winner),
    .found  (arb_found)
  );

  assign credit_ok   = (credit_cnt_reg != '0);
  assign credit_full = (credit_cnt_reg == CNTW'(CREDITS));
  assign owner_req   = any_req[owner_reg];
  assign owner_tail  = tail[owner_reg];
  assign granted     = |grt_raw;

`ifdef MUXCONT_LOCK_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);

  logic [TOW-1:0] idle_cnt_reg, idle_cnt_next;

  // Count consecutive owner-silent cycles while locked; the cycle that would
  // reach TIMEOUT releases the lock instead of incrementing.
  always_comb begin
    idle_cnt_next = '0;
    lock_expire   = 1'b0;
    if (state_reg == LOCKED && !owner_req) begin
      if (idle_cnt_reg == TOW'(TIMEOUT - 1)) begin
        lock_expire = 1'b1;
      end else begin
        idle_cnt_next = idle_cnt_reg + 1'b1;
      end
    end
  end

  // Idle counter register; held at zero outside LOCKED so entry starts clean.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  assign lock_timeout = lock_expire & (rst_ != ENABLE_);
`else
  // Without the timeout the lock is only ever released by a tail flit.
  assign lock_expire  = 1'b0;
  assign lock_timeout = 1'b0;
`endif

  // Arbitration and packet lock: next state, pointer, owner and raw grant.
  always_comb begin
    grt_raw    = '0;
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE: begin
        if (credit_ok && arb_found) begin
          grt_raw  = arb_gnt;
          ptr_next = (arb_winner == PTRW'(NPORT - 1)) ? '0 : arb_winner + 1'b1;
          if (!tail[arb_winner]) begin
            state_next = LOCKED;
            owner_next = arb_winner;
          end
        end
      end
      LOCKED: begin
        if (owner_req && credit_ok) begin
          grt_raw[owner_reg] = 1'b1;
          if (owner_tail) begin
            state_next = IDLE;
          end
        end else if (lock_expire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lock state, rotating pointer and owner registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // Crossbar select follows the grant by one cycle to match its pipeline.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sel_reg <= '0;
    end else begin
      sel_reg <= grt_raw;
    end
  end

  // Credit counter: grants consume, returns refill (saturating), both cancel.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credit_cnt_reg <= CNTW'(CREDITS);
      credit_ovf_reg <= 1'b0;
    end else begin
      credit_ovf_reg <= credit_in & ~granted & credit_full;
      case ({granted, credit_in})
        2'b10:   credit_cnt_reg <= credit_cnt_reg - 1'b1;
        2'b01:   if (!credit_full) credit_cnt_reg <= credit_cnt_reg + 1'b1;
        default: credit_cnt_reg <= credit_cnt_reg;
      endcase
    end
  end

  // Combinational outputs are silenced while reset is asserted.
  assign out_en = (rst_ != ENABLE_);

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
    assign grt[gi]       = grt_raw[gi] & out_en;
    assign multab_ct[gi] = m_req[gi] & ~grt_raw[gi] & out_en;
  end

  assign sel        = sel_reg;
  assign credit_cnt = credit_cnt_reg;
  assign credit_ovf = credit_ovf_reg;

endmodule

// File: tb/tb_muxcont_rr_credit.sv
// Scoreboard bench for muxcont_rr_credit (NPORT=5, PORTID=4, CREDITS=4).
// The driver applies one directed vector per cycle and queues the
// hand-computed response; the monitor pops and compares at each falling edge.
module tb_muxcont_rr_credit;
  import muxcont_rr_credit_pkg::*;

  logic        clk;
  logic        rst_;
  logic [4:0]  req;
  logic [14:0] port;
  logic [9:0]  multab;
  logic [4:0]  tail;
  logic        credit_in;
  logic [4:0]  grt;
  logic [4:0]  sel;
  logic [4:0]  multab_ct;
  logic [2:0]  credit_cnt;
  logic        credit_ovf;
  logic        lock_timeout;

  logic [14:0] nxt_port;
  logic [9:0]  nxt_multab;

  typedef struct {
    logic [4:0] grt;
    logic [4:0] mct;
    logic [4:0] sel;
    logic [2:0] cnt;
    logic       ovf;
    logic       lt;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;
  int txn    = 0;

  muxcont_rr_credit #(
    .NPORT(5), .PORTID(4), .PORTW(3), .DSTW(2), .CREDITS(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_(rst_), .req(req), .port(port), .multab(multab),
    .tail(tail), .credit_in(credit_in), .grt(grt), .sel(sel),
    .multab_ct(multab_ct), .credit_cnt(credit_cnt), .credit_ovf(credit_ovf),
    .lock_timeout(lock_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%0h expected=%0h", nm, txn, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic ci,
                      input logic [4:0] eg, input logic [4:0] em,
                      input logic [4:0] es, input logic [2:0] ec,
                      input logic eo, input logic el);
    exp_t e;
    @(posedge clk);
    #1;
    req       = r;
    tail      = t;
    credit_in = ci;
    port      = nxt_port;
    multab    = nxt_multab;
    e.grt = eg; e.mct = em; e.sel = es; e.cnt = ec; e.ovf = eo; e.lt = el;
    expq.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("grt",          int'(grt),          int'(e.grt));
        cmp("multab_ct",    int'(multab_ct),    int'(e.mct));
        cmp("sel",          int'(sel),          int'(e.sel));
        cmp("credit_cnt",   int'(credit_cnt),   int'(e.cnt));
        cmp("credit_ovf",   int'(credit_ovf),   int'(e.ovf));
        cmp("lock_timeout", int'(lock_timeout), int'(e.lt));
        $display("txn %0d req=%b grt=%b multab_ct=%b sel=%b credit_cnt=%0d ovf=%b lt=%b",
                 txn, req, grt, multab_ct, sel, credit_cnt, credit_ovf, lock_timeout);
        txn++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] pp;
    logic [9:0]  mm;
    logic [4:0]  eg, es;
    logic [2:0]  ec;
    logic        el;
    int          wait_cycles;

    rst_       = 1'b0;
    req        = '0;
    tail       = '0;
    credit_in  = 1'b0;
    nxt_port   = {5{3'd4}};
    nxt_multab = {5{UNICAST}};
    port       = nxt_port;
    multab     = nxt_multab;

    repeat (2) @(posedge clk);
    #2;
    cmp("reset credit_cnt", int'(credit_cnt), 4);
    cmp("reset sel",        int'(sel),        0);
    cmp("reset grt",        int'(grt),        0);
    #1 rst_ = 1'b1;

    // Round-robin between inputs 0 and 2, credits returned every cycle.
    step(5'b00101, 5'b11111, 1'b1, 5'b00001, 5'b0, 5'b00000, 3'd4, 1'b0, 1'b0);
    step(5'b00101, 5'b11111, 1'b1, 5'b00100, 5'b0, 5'b00001, 3'd4, 1'b0, 1'b0);
    step(5'b00101, 5'b11111, 1'b1, 5'b00001, 5'b0, 5'b00100, 3'd4, 1'b0, 1'b0);
    step(5'b00101, 5'b11111, 1'b1, 5'b00100, 5'b0, 5'b00001, 3'd4, 1'b0, 1'b0);

    // Move the pointer to 4, then lock onto input 1 while input 3 waits.
    step(5'b01000, 5'b11111, 1'b1, 5'b01000, 5'b0, 5'b00100, 3'd4, 1'b0, 1'b0);
    step(5'b01010, 5'b11101, 1'b1, 5'b00010, 5'b0, 5'b01000, 3'd4, 1'b0, 1'b0);
    step(5'b01010, 5'b11101, 1'b1, 5'b00010, 5'b0, 5'b00010, 3'd4, 1'b0, 1'b0);
    step(5'b01010, 5'b11111, 1'b1, 5'b00010, 5'b0, 5'b00010, 3'd4, 1'b0, 1'b0);
    step(5'b01000, 5'b11111, 1'b1, 5'b01000, 5'b0, 5'b00010, 3'd4, 1'b0, 1'b0);

    // Credit exhaustion from input 0, single credit return, refill, overflow.
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b01000, 3'd4, 1'b0, 1'b0);
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00001, 3'd3, 1'b0, 1'b0);
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00001, 3'd2, 1'b0, 1'b0);
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00001, 3'd1, 1'b0, 1'b0);
    step(5'b00001, 5'b11111, 1'b0, 5'b00000, 5'b0, 5'b00001, 3'd0, 1'b0, 1'b0);
    step(5'b00001, 5'b11111, 1'b1, 5'b00000, 5'b0, 5'b00000, 3'd0, 1'b0, 1'b0);
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00000, 3'd1, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b0, 5'b00001, 3'd0, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b0, 5'b00000, 3'd0, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b0, 5'b00000, 3'd1, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b0, 5'b00000, 3'd2, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b0, 5'b00000, 3'd3, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b0, 5'b00000, 3'd4, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b0, 5'b00000, 3'd4, 1'b1, 1'b0);
    step(5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b0, 5'b00000, 3'd4, 1'b0, 1'b0);

    // Pointer to 0 via input 4, then multicast contention 0 vs 4.
    step(5'b10000, 5'b11111, 1'b1, 5'b10000, 5'b0, 5'b00000, 3'd4, 1'b0, 1'b0);
    mm = {5{UNICAST}};
    mm[1:0] = MULTABS;
    mm[9:8] = MULTABS;
    nxt_multab = mm;
    step(5'b10001, 5'b11111, 1'b1, 5'b00001, 5'b10000, 5'b10000, 3'd4, 1'b0, 1'b0);
    // Unicast to another port is ignored; multicast input 2 wins.
    pp = {5{3'd4}};
    pp[5:3] = 3'd2;
    nxt_port = pp;
    mm = {5{UNICAST}};
    mm[5:4] = MULTABS;
    nxt_multab = mm;
    step(5'b00110, 5'b11111, 1'b1, 5'b00100, 5'b00000, 5'b00001, 3'd4, 1'b0, 1'b0);
    nxt_port   = {5{3'd4}};
    nxt_multab = {5{UNICAST}};

    // Lock onto input 0, then owner goes silent while input 1 requests.
    step(5'b00001, 5'b11110, 1'b0, 5'b00001, 5'b0, 5'b00100, 3'd4, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      eg = 5'b00000;
      es = (k == 1) ? 5'b00001 : 5'b00000;
      el = 1'b0;
`ifdef MUXCONT_LOCK_TIMEOUT_EN
      if (k == 16) el = 1'b1;
      if (k == 17) eg = 5'b00010;
`endif
      step(5'b00010, 5'b11111, 1'b0, eg, 5'b0, es, 3'd3, 1'b0, el);
    end
`ifdef MUXCONT_LOCK_TIMEOUT_EN
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00010, 3'd2, 1'b0, 1'b0);
    ec = 3'd1;
`else
    step(5'b00001, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00000, 3'd3, 1'b0, 1'b0);
    ec = 3'd2;
`endif
    mm = {5{UNICAST}};
    mm[1:0] = MULTABS;
    mm[9:8] = MULTABS;
    nxt_multab = mm;
    step(5'b10001, 5'b11111, 1'b0, 5'b10000, 5'b00001, 5'b00001, ec, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with requests still active.
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    cmp("async grt",          int'(grt),          0);
    cmp("async multab_ct",    int'(multab_ct),    0);
    cmp("async sel",          int'(sel),          0);
    cmp("async credit_cnt",   int'(credit_cnt),   4);
    cmp("async credit_ovf",   int'(credit_ovf),   0);
    cmp("async lock_timeout", int'(lock_timeout), 0);
    req        = '0;
    nxt_multab = {5{UNICAST}};
    multab     = nxt_multab;
    @(posedge clk);
    #2 rst_ = 1'b1;

    // Pointer restarts at 0 after reset.
    step(5'b00101, 5'b11111, 1'b0, 5'b00001, 5'b0, 5'b00000, 3'd4, 1'b0, 1'b0);
    step(5'b00101, 5'b11111, 1'b0, 5'b00100, 5'b0, 5'b00001, 3'd3, 1'b0, 1'b0);
    step(5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b0, 5'b00100, 3'd2, 1'b0, 1'b0);

    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxcont_rr_credit.md
Name: muxcont_rr_credit

Overview:
- Parametrised output-port contention controller for the router crossbar; successor to the fixed 5-port mux controller.
- Generalised to NPORT inputs with an internal rotating-priority arbiter and a packet-level lock that holds the output until the tail flit.
- Adds credit-based flow control toward the downstream buffer.
- One instance per output port; drives the crossbar select and the per-input grants.

Parameters:
- NPORT, 5, number of input ports contending for this output
- PORTID, 4, output port index this instance owns
- PORTW, 3, width of each routed-port field
- DSTW, 2, width of each multicast/absorb status field
- CREDITS, 4, downstream buffer depth; credit counter reset value
- TIMEOUT, 16, lock-idle limit in cycles (optional feature only)

Ports:
- clk  in  1  clock
- rst_  in  1  asynchronous active-low reset
- req  in  NPORT  per-input flit valid
- port  in  NPORT*PORTW  routed output port per input; input i at [i*PORTW +: PORTW]
- multab  in  NPORT*DSTW  status per input: UNICAST or MULTABS
- tail  in  NPORT  flit on input i is a tail (single-flit packet = head+tail)
- credit_in  in  1  downstream returns one credit
- grt  out  NPORT  one-hot/zero combinational grant; one flit transfers
- sel  out  NPORT  registered crossbar select
- multab_ct  out  NPORT  multicast request lost contention this cycle
- credit_cnt  out  $clog2(CREDITS+1)  available credits
- credit_ovf  out  1  one-cycle pulse: credit returned while counter full
- lock_timeout  out  1  one-cycle pulse; tied 0 without the optional feature

Behaviour:
- Clock and reset: single clock clk; reset rst_ is asynchronous and active-low.
- Request qualification:
  - u_req[i] = req[i] & multab_i==UNICAST & port_i==PORTID
  - m_req[i] = req[i] & multab_i==MULTABS
  - any_req = u_req | m_req
- State IDLE:
  - If credit_cnt>0 and any_req!=0, the rr_arbiter picks the first requester scanning from ptr upward with wrap; grt = that one-hot.
  - ptr <= winner+1 mod NPORT.
  - If tail[winner]=1, stay IDLE; otherwise go to LOCKED with owner<=winner.
  - If credit_cnt==0, grt=0 and ptr is unchanged.
- State LOCKED:
  - grt[owner] = any_req[owner] & credit_cnt>0; all other grt bits are 0.
  - Other requesters are ignored and ptr does not move.
  - A granted flit with tail[owner]=1 returns the state to IDLE in the next cycle.
- sel <= grt every cycle (one-cycle delay matching the crossbar register).
- multab_ct[i] = m_req[i] & ~grt[i], combinational.
- Credit counter:
  - Grant only: decrement.
  - credit_in only: increment, saturating at CREDITS.
  - Grant and credit_in in the same cycle: unchanged.
  - credit_in while counter==CREDITS and no grant: hold at CREDITS, pulse credit_ovf.
  - Underflow is impossible: no grant is issued at 0.
- Simultaneous events:
  - Owner's tail flit plus a new request in the same cycle: the new request waits one cycle; arbitration happens from IDLE.
  - Only one grant per cycle, ever.
- Reset (including mid-packet):
  - State IDLE, ptr=0, owner cleared, sel=0, credit_cnt=CREDITS, credit_ovf=0, lock_timeout=0.
  - grt and multab_ct are forced to 0 while rst_=0.
  - A partially sent packet is abandoned.

Optional Feature:
- Macro: MUXCONT_LOCK_TIMEOUT_EN.
- Defined:
  - In LOCKED, a counter counts consecutive cycles with any_req[owner]=0 and clears on any owner request.
  - On reaching TIMEOUT, the lock is released (IDLE next cycle) and lock_timeout pulses for one cycle.
  - The counter clears on reset and on entry to LOCKED.
- Undefined: the lock is held indefinitely until tail; lock_timeout tied 0; no counter logic.

Decomposition:
- Shared package/header: UNICAST and MULTABS encodings, DSTW, PORTW, Enable_ polarity constant, IDLE/LOCKED state encoding.
- Sub-module rr_arbiter (NPORT param): inputs req vector and ptr, output one-hot winner; purely combinational rotating priority, reusable by other output controllers.

Test Plan:
All cases use NPORT=5, PORTID=4, CREDITS=4 unless noted.
- Reset: assert rst_=0 asynchronously mid-cycle -> credit_cnt=4, grt=0, sel=0, multab_ct=0 immediately; release -> IDLE, ptr=0.
- Round-robin fairness: inputs 0 and 2 unicast port=4 tail=1 every cycle, credit_in=1 every cycle -> grt sequence 00001, 00100, 00001, 00100; sel follows one cycle later; credit_cnt stays 4.
- Packet lock: input 1 head (tail=0) granted at cycle 0; input 3 requests from cycle 0; input 1 body at cycle 1, tail at cycle 2 -> grt=00010 at cycles 0-2, grt=01000 at cycle 3.
- Credit exhaustion: no credit_in, five single-flit requests from input 0 -> four grants, credit_cnt=0, grt=0 afterwards. One credit_in -> grant next cycle, credit_cnt stays 0. credit_in while credit_cnt=4 -> credit_ovf pulses, count stays 4.
- Multicast contention: inputs 0 and 4 both MULTABS in the same cycle with ptr=0 -> grt=00001, multab_ct=10000.
- Timeout (macro defined, TIMEOUT=16): owner of a locked packet drops req for 16 cycles -> lock_timeout pulses on cycle 16, next cycle another requester is granted. With the macro undefined, the lock persists and lock_timeout stays 0.
